// File: rtl/ibex_trace_pkg.sv
// Shared types for the Ibex retirement trace recorder: record layout, capture modes
// and recorder FSM states.
package ibex_trace_pkg;

   localparam int unsigned TraceRecW = 104;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_FILL = 2'd1,
      MODE_WRAP = 2'd2,
      MODE_RSVD = 2'd3
   } trace_mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      POSTTRIG = 2'd2,
      FROZEN   = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic        gap;
      logic        trap;
      logic        intr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] insn;
      logic [31:0] pc;
   } trace_rec_t;

endpackage

// File: rtl/ibex_trace_capture_if.sv
// RVFI retirement inputs and the record drain stream of the trace recorder.
// The slave modport is the recorder's view; master is the core/consumer side.
interface ibex_trace_capture_if;
   import ibex_trace_pkg::*;

   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_intr;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic        out_valid;
   logic        out_ready;
   trace_rec_t  out_rec;

   modport master (
      output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap,
             rvfi_intr, rvfi_rd_addr, rvfi_rd_wdata, out_ready,
      input  out_valid, out_rec
   );

   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap,
             rvfi_intr, rvfi_rd_addr, rvfi_rd_wdata, out_ready,
      output out_valid, out_rec
   );

endinterface

// File: rtl/ibex_trace_ring.sv
// Ring buffer for trace records: flop storage, pointers, occupancy count and
// push/pop/overwrite arbitration. Head is read combinationally and zeroed when empty.
module ibex_trace_ring #(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = 104
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic                    push_i,
   input  logic                    wrap_i,
   input  logic [Width-1:0]        wdata_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic [Width-1:0]        rdata_o,
   output logic [$clog2(Depth):0]  level_o,
   output logic                    drop_o
);
   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [PtrW:0]    r_count;
   logic             w_full;
   logic             w_pop;
   logic             w_wr_en;
   logic             w_rd_adv;

   assign w_full   = (r_count == (PtrW+1)'(Depth));
   assign valid_o  = (r_count != '0);
   assign w_pop    = valid_o && ready_i && !clr_i;
   // A full buffer still accepts a push if the head leaves this cycle or we overwrite.
   assign w_wr_en  = push_i && (!w_full || w_pop || wrap_i);
   assign w_rd_adv = w_pop || (w_wr_en && w_full);
   assign drop_o   = push_i && w_full && !w_pop && !wrap_i;
   assign rdata_o  = valid_o ? r_mem[r_rptr] : '0;
   assign level_o  = r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_en) begin
            r_wptr <= r_wptr + PtrW'(1);
         end
         if (w_rd_adv) begin
            r_rptr <= r_rptr + PtrW'(1);
         end
         if (w_wr_en && !w_rd_adv) begin
            r_count <= r_count + (PtrW+1)'(1);
         end else if (!w_wr_en && w_rd_adv) begin
            r_count <= r_count - (PtrW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[r_wptr] <= wdata_i;
      end
   end

endmodule

// File: rtl/ibex_trace_capture.sv
// Retirement trace recorder: capture FSM, post-trigger countdown, order-gap
// detection and saturating drop counter in front of the record ring.
module ibex_trace_capture
   import ibex_trace_pkg::*;
#(
   parameter int unsigned Depth        = 16,
   parameter int unsigned PostTrigCnt  = 8,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [1:0]               mode_i,
   input  logic                     clear_i,
   ibex_trace_capture_if.slave      bus,
   output logic [$clog2(Depth):0]   level_o,
   output logic [DropCntWidth-1:0]  dropped_o,
   output logic                     frozen_o
);
   localparam int unsigned CntW = (PostTrigCnt == 0) ? 1 : $clog2(PostTrigCnt + 1);

   trace_state_e           r_state;
   trace_state_e           w_state_next;
   logic [CntW-1:0]        r_trig_cnt;
   logic [CntW-1:0]        w_trig_cnt_next;
   logic [63:0]            r_last_order;
   logic                   r_have_last;
   logic [DropCntWidth-1:0] r_dropped;
   logic                   w_mode_on;
   logic                   w_wrap;
   logic                   w_capturing;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_gap;
   logic                   w_valid;
   trace_rec_t             w_rec;
   logic [TraceRecW-1:0]   w_rdata;

   assign w_mode_on   = (mode_i == MODE_FILL) || (mode_i == MODE_WRAP);
   assign w_wrap      = (mode_i == MODE_WRAP);
   assign w_capturing = (r_state == CAPTURE) || (r_state == POSTTRIG);
   assign w_push      = w_capturing && bus.rvfi_valid && !clear_i;
   assign w_gap       = r_have_last && (bus.rvfi_order != r_last_order + 64'd1);

   assign w_rec = '{gap: w_gap, trap: bus.rvfi_trap, intr: bus.rvfi_intr,
                    rd_addr: bus.rvfi_rd_addr, rd_wdata: bus.rvfi_rd_wdata,
                    insn: bus.rvfi_insn, pc: bus.rvfi_pc_rdata};

   ibex_trace_ring #(
      .Depth (Depth),
      .Width (TraceRecW)
   ) u_ring (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clear_i),
      .push_i  (w_push),
      .wrap_i  (w_wrap),
      .wdata_i (w_rec),
      .ready_i (bus.out_ready),
      .valid_o (w_valid),
      .rdata_o (w_rdata),
      .level_o (level_o),
      .drop_o  (w_drop)
   );

   assign bus.out_valid = w_valid;
   assign bus.out_rec   = w_rdata;
   assign dropped_o     = r_dropped;
   assign frozen_o      = (r_state == FROZEN);

   always_comb begin
      w_state_next    = r_state;
      w_trig_cnt_next = r_trig_cnt;
      case (r_state)
         IDLE: begin
            if (w_mode_on) w_state_next = CAPTURE;
         end
         CAPTURE: begin
            if (!w_mode_on) begin
               w_state_next = IDLE;
            end else if (w_push && w_wrap && bus.rvfi_trap) begin
               if (PostTrigCnt == 0) begin
                  w_state_next = FROZEN;
               end else begin
                  w_state_next    = POSTTRIG;
                  w_trig_cnt_next = CntW'(PostTrigCnt);
               end
            end
         end
         POSTTRIG: begin
            // Later traps are recorded but never reload the countdown.
            if (!w_mode_on) begin
               w_state_next = IDLE;
            end else if (w_push) begin
               w_trig_cnt_next = r_trig_cnt - CntW'(1);
               if (r_trig_cnt == CntW'(1)) w_state_next = FROZEN;
            end
         end
         FROZEN: begin
            w_state_next = FROZEN;
         end
         default: w_state_next = IDLE;
      endcase
      if (clear_i) begin
         w_state_next    = IDLE;
         w_trig_cnt_next = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_trig_cnt   <= '0;
         r_last_order <= '0;
         r_have_last  <= 1'b0;
         r_dropped    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_trig_cnt <= w_trig_cnt_next;
         if (clear_i) begin
            r_last_order <= '0;
            r_have_last  <= 1'b0;
            r_dropped    <= '0;
         end else begin
            // Dropped retirements still advance the order tracker.
            if (w_capturing && bus.rvfi_valid) begin
               r_last_order <= bus.rvfi_order;
               r_have_last  <= 1'b1;
            end
            if (w_drop && (r_dropped != '1)) begin
               r_dropped <= r_dropped + DropCntWidth'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ibex_trace_capture.sv
// Directed bench for ibex_trace_capture: a per-cycle vector table plus hand-written
// FILL, WRAP, clear, reset and small-counter sequences on two configurations.
module tb_ibex_trace_capture;
   import ibex_trace_pkg::*;

   typedef struct {
      logic [1:0]  mode;
      logic        clr;
      logic        vld;
      logic [63:0] order;
      logic        trap;
      logic        rdy;
      int          exp_level;
      logic        exp_valid;
      logic        exp_frozen;
      int          exp_drop;
      logic [63:0] exp_order;
      logic        exp_gap;
      logic        exp_trap;
   } vec_t;

   localparam int NV = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode_a, mode_b;
   logic        clear_a, clear_b;
   logic [4:0]  level_a;
   logic [15:0] dropped_a;
   logic        frozen_a;
   logic [2:0]  level_b;
   logic [1:0]  dropped_b;
   logic        frozen_b;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs [NV];

   ibex_trace_capture_if bus_a ();
   ibex_trace_capture_if bus_b ();

   always #5 clk = ~clk;

   ibex_trace_capture u_dut_a (
      .clk_i     (clk),
      .rst_i     (rst),
      .mode_i    (mode_a),
      .clear_i   (clear_a),
      .bus       (bus_a),
      .level_o   (level_a),
      .dropped_o (dropped_a),
      .frozen_o  (frozen_a)
   );

   ibex_trace_capture #(
      .Depth        (4),
      .PostTrigCnt  (0),
      .DropCntWidth (2)
   ) u_dut_b (
      .clk_i     (clk),
      .rst_i     (rst),
      .mode_i    (mode_b),
      .clear_i   (clear_b),
      .bus       (bus_b),
      .level_o   (level_b),
      .dropped_o (dropped_b),
      .frozen_o  (frozen_b)
   );

   function automatic trace_rec_t mk_rec(input logic [63:0] ord, input logic trap, input logic gap);
      trace_rec_t r;
      r.gap      = gap;
      r.trap     = trap;
      r.intr     = (ord[2:0] == 3'd0);
      r.rd_addr  = ord[4:0];
      r.rd_wdata = ~ord[31:0];
      r.insn     = {ord[15:0], 16'h0013};
      r.pc       = 32'h8000_0000 + {ord[29:0], 2'b00};
      return r;
   endfunction

   task automatic drv_a(input logic v, input logic [63:0] ord, input logic trap);
      trace_rec_t r;
      r = mk_rec(ord, trap, 1'b0);
      bus_a.rvfi_valid    = v;
      bus_a.rvfi_order    = ord;
      bus_a.rvfi_pc_rdata = r.pc;
      bus_a.rvfi_insn     = r.insn;
      bus_a.rvfi_trap     = trap;
      bus_a.rvfi_intr     = r.intr;
      bus_a.rvfi_rd_addr  = r.rd_addr;
      bus_a.rvfi_rd_wdata = r.rd_wdata;
   endtask

   task automatic drv_b(input logic v, input logic [63:0] ord, input logic trap);
      trace_rec_t r;
      r = mk_rec(ord, trap, 1'b0);
      bus_b.rvfi_valid    = v;
      bus_b.rvfi_order    = ord;
      bus_b.rvfi_pc_rdata = r.pc;
      bus_b.rvfi_insn     = r.insn;
      bus_b.rvfi_trap     = trap;
      bus_b.rvfi_intr     = r.intr;
      bus_b.rvfi_rd_addr  = r.rd_addr;
      bus_b.rvfi_rd_wdata = r.rd_wdata;
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_rec(input string name, input trace_rec_t act, input trace_rec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_wrap_a;
      clear_a = 1'b1;
      mode_a  = MODE_WRAP;
      tick();
      clear_a = 1'b0;
      tick();
      for (int i = 0; i < 40; i++) begin
         drv_a(1'b1, 64'(i), (i == 30));
         tick();
         if (i == 37) chk_int("wrap_not_frozen_37", int'(frozen_a), 0);
         if (i == 38) chk_int("wrap_frozen_38", int'(frozen_a), 1);
      end
      drv_a(1'b0, 64'd0, 1'b0);
      chk_int("wrap_level", int'(level_a), 16);
      chk_int("wrap_dropped", int'(dropped_a), 0);
   endtask

   initial begin
      // mode clr vld order trap rdy | level valid frozen drop | head order gap trap
      vecs[0]  = '{MODE_FILL, 1'b1, 1'b1, 64'd100, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 64'd0,  1'b0, 1'b0};
      vecs[1]  = '{MODE_FILL, 1'b0, 1'b1, 64'd200, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 64'd0,  1'b0, 1'b0};
      vecs[2]  = '{MODE_FILL, 1'b0, 1'b1, 64'd5,   1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 64'd5,  1'b0, 1'b0};
      vecs[3]  = '{MODE_FILL, 1'b0, 1'b1, 64'd6,   1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 64'd5,  1'b0, 1'b0};
      vecs[4]  = '{MODE_FILL, 1'b0, 1'b1, 64'd9,   1'b0, 1'b0, 3, 1'b1, 1'b0, 0, 64'd5,  1'b0, 1'b0};
      vecs[5]  = '{MODE_FILL, 1'b0, 1'b0, 64'd0,   1'b0, 1'b1, 2, 1'b1, 1'b0, 0, 64'd6,  1'b0, 1'b0};
      vecs[6]  = '{MODE_FILL, 1'b0, 1'b0, 64'd0,   1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 64'd9,  1'b1, 1'b0};
      vecs[7]  = '{MODE_FILL, 1'b0, 1'b0, 64'd0,   1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 64'd0,  1'b0, 1'b0};
      vecs[8]  = '{MODE_FILL, 1'b0, 1'b1, 64'd10,  1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 64'd10, 1'b0, 1'b0};
      vecs[9]  = '{MODE_OFF,  1'b0, 1'b1, 64'd11,  1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 64'd10, 1'b0, 1'b0};
      vecs[10] = '{MODE_OFF,  1'b0, 1'b1, 64'd12,  1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 64'd10, 1'b0, 1'b0};
      vecs[11] = '{MODE_OFF,  1'b0, 1'b0, 64'd0,   1'b0, 1'b1, 1, 1'b1, 1'b0, 0, 64'd11, 1'b0, 1'b0};
      vecs[12] = '{MODE_OFF,  1'b0, 1'b0, 64'd0,   1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 64'd0,  1'b0, 1'b0};

      rst     = 1'b1;
      mode_a  = MODE_OFF;
      mode_b  = MODE_OFF;
      clear_a = 1'b0;
      clear_b = 1'b0;
      bus_a.out_ready = 1'b0;
      bus_b.out_ready = 1'b0;
      drv_a(1'b0, 64'd0, 1'b0);
      drv_b(1'b0, 64'd0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      chk_int("rst_level", int'(level_a), 0);
      chk_int("rst_valid", int'(bus_a.out_valid), 0);
      chk_rec("rst_rec", bus_a.out_rec, '0);
      chk_int("rst_dropped", int'(dropped_a), 0);
      chk_int("rst_frozen", int'(frozen_a), 0);

      // FILL: 20 records into 16 slots, then a push+pop on the full buffer
      mode_a = MODE_FILL;
      tick();
      for (int i = 0; i < 20; i++) begin
         drv_a(1'b1, 64'(i), 1'b0);
         tick();
         if (i == 0) begin
            chk_int("fill_first_valid", int'(bus_a.out_valid), 1);
            chk_rec("fill_first_rec", bus_a.out_rec, mk_rec(64'd0, 1'b0, 1'b0));
         end
      end
      drv_a(1'b0, 64'd0, 1'b0);
      chk_int("fill_level", int'(level_a), 16);
      chk_int("fill_dropped", int'(dropped_a), 4);
      chk_rec("fill_head", bus_a.out_rec, mk_rec(64'd0, 1'b0, 1'b0));
      drv_a(1'b1, 64'd20, 1'b0);
      bus_a.out_ready = 1'b1;
      tick();
      drv_a(1'b0, 64'd0, 1'b0);
      bus_a.out_ready = 1'b0;
      chk_int("fill_pushpop_level", int'(level_a), 16);
      chk_int("fill_pushpop_dropped", int'(dropped_a), 4);
      bus_a.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         logic [63:0] eo;
         eo = (k < 15) ? 64'(k + 1) : 64'd20;
         chk_rec($sformatf("fill_drain_%0d", k), bus_a.out_rec, mk_rec(eo, 1'b0, 1'b0));
         tick();
      end
      bus_a.out_ready = 1'b0;
      chk_int("fill_empty_level", int'(level_a), 0);
      chk_int("fill_empty_valid", int'(bus_a.out_valid), 0);

      // Table: clear, order gap, mode OFF retention
      for (int i = 0; i < NV; i++) begin
         mode_a  = vecs[i].mode;
         clear_a = vecs[i].clr;
         drv_a(vecs[i].vld, vecs[i].order, vecs[i].trap);
         bus_a.out_ready = vecs[i].rdy;
         tick();
         chk_int($sformatf("vec%0d_level", i), int'(level_a), vecs[i].exp_level);
         chk_int($sformatf("vec%0d_valid", i), int'(bus_a.out_valid), int'(vecs[i].exp_valid));
         chk_int($sformatf("vec%0d_frozen", i), int'(frozen_a), int'(vecs[i].exp_frozen));
         chk_int($sformatf("vec%0d_dropped", i), int'(dropped_a), vecs[i].exp_drop);
         chk_rec($sformatf("vec%0d_rec", i), bus_a.out_rec,
                 vecs[i].exp_valid ? mk_rec(vecs[i].exp_order, vecs[i].exp_trap, vecs[i].exp_gap) : '0);
      end
      clear_a = 1'b0;
      bus_a.out_ready = 1'b0;
      drv_a(1'b0, 64'd0, 1'b0);

      // WRAP flight recorder: trap at 30, freeze after 38, drain 23..38
      run_wrap_a();
      mode_a = MODE_OFF;
      tick();
      chk_int("frozen_ignores_mode", int'(frozen_a), 1);
      mode_a = MODE_WRAP;
      bus_a.out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         logic [63:0] eo;
         eo = 64'(23 + k);
         chk_rec($sformatf("wrap_drain_%0d", k), bus_a.out_rec, mk_rec(eo, (eo == 64'd30), 1'b0));
         tick();
      end
      bus_a.out_ready = 1'b0;
      chk_int("wrap_empty_level", int'(level_a), 0);
      chk_int("wrap_still_frozen", int'(frozen_a), 1);

      // Clear while frozen and full, with a simultaneous retirement
      run_wrap_a();
      clear_a = 1'b1;
      drv_a(1'b1, 64'd50, 1'b0);
      tick();
      clear_a = 1'b0;
      drv_a(1'b1, 64'd51, 1'b0);
      chk_int("clr_level", int'(level_a), 0);
      chk_int("clr_valid", int'(bus_a.out_valid), 0);
      chk_int("clr_frozen", int'(frozen_a), 0);
      chk_rec("clr_rec", bus_a.out_rec, '0);
      tick();
      chk_int("clr_idle_no_push", int'(level_a), 0);

      // Reset in the middle of the post-trigger window
      drv_a(1'b1, 64'd0, 1'b1);
      tick();
      drv_a(1'b1, 64'd1, 1'b0);
      tick();
      chk_int("posttrig_level", int'(level_a), 2);
      rst = 1'b1;
      drv_a(1'b0, 64'd0, 1'b0);
      tick();
      rst = 1'b0;
      chk_int("midrst_level", int'(level_a), 0);
      chk_int("midrst_valid", int'(bus_a.out_valid), 0);
      chk_rec("midrst_rec", bus_a.out_rec, '0);
      chk_int("midrst_frozen", int'(frozen_a), 0);
      chk_int("midrst_dropped", int'(dropped_a), 0);
      drv_a(1'b1, 64'd2, 1'b0);
      tick();
      drv_a(1'b0, 64'd0, 1'b0);
      chk_int("midrst_idle_no_push", int'(level_a), 0);

      // Small config: 2-bit drop counter saturates, PostTrigCnt=0 freezes on the trap
      mode_b = MODE_FILL;
      tick();
      for (int i = 0; i < 9; i++) begin
         drv_b(1'b1, 64'(i), 1'b0);
         tick();
         if (i == 5) chk_int("b_dropped_2", int'(dropped_b), 2);
      end
      drv_b(1'b0, 64'd0, 1'b0);
      chk_int("b_level_full", int'(level_b), 4);
      chk_int("b_dropped_sat", int'(dropped_b), 3);
      chk_rec("b_head", bus_b.out_rec, mk_rec(64'd0, 1'b0, 1'b0));
      clear_b = 1'b1;
      mode_b  = MODE_WRAP;
      tick();
      clear_b = 1'b0;
      tick();
      chk_int("b_clr_dropped", int'(dropped_b), 0);
      for (int i = 0; i < 3; i++) begin
         drv_b(1'b1, 64'(i), (i == 2));
         tick();
      end
      chk_int("b_trig_frozen", int'(frozen_b), 1);
      drv_b(1'b1, 64'd3, 1'b0);
      tick();
      drv_b(1'b0, 64'd0, 1'b0);
      chk_int("b_frozen_level", int'(level_b), 3);
      chk_rec("b_frozen_head", bus_b.out_rec, mk_rec(64'd0, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
